// File: rtl/param_width_deser_if.sv
// Link bundle for param_width_deser: the narrow beat stream in, the packed word stream out.
// The slave modport is the gearbox; the master modport is whatever drives and drains it.
interface param_width_deser_if #(
   parameter int IN_WIDTH = 8,
   parameter int RATIO    = 2
);
   localparam int OUT_WIDTH = IN_WIDTH * RATIO;
   localparam int CNT_W     = $clog2(RATIO + 1);

   logic                 in_valid;
   logic                 in_ready;
   logic [IN_WIDTH-1:0]  in_data;
   logic                 in_last;
   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_WIDTH-1:0] out_data;
   logic [CNT_W-1:0]     out_count;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_count
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_count
   );
endinterface

// File: rtl/param_width_deser.sv
// Receive-side gearbox: packs RATIO narrow beats (or fewer, on in_last) into one wide
// registered word, beat k in bits [k*IN_WIDTH +: IN_WIDTH].
module param_width_deser #(
   parameter int IN_WIDTH = 8,
   parameter int RATIO    = 2
) (
   input logic               clk,
   input logic               rst,
   param_width_deser_if.slave link
);
   localparam int OUT_WIDTH = IN_WIDTH * RATIO;
   localparam int CNT_W     = $clog2(RATIO + 1);

   // Both sides use valid/ready: a transfer happens on any rising edge where valid and
   // ready are both high; valid never waits on ready, and a raised valid holds its
   // payload until that transfer.

   logic [OUT_WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 out_valid_q, out_valid_d;
   logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
   logic [CNT_W-1:0]     out_count_q, out_count_d;

   logic                 in_ready;
   logic                 accept;
   logic                 complete;
   logic [OUT_WIDTH-1:0] merged;

   always_comb begin
      in_ready    = !out_valid_q || link.out_ready;
      accept      = link.in_valid && in_ready;
      complete    = accept && ((cnt_q == CNT_W'(RATIO - 1)) || link.in_last);
      // Slots above cnt are already zero because acc is cleared on every completion.
      merged      = acc_q;
      merged[int'(cnt_q) * IN_WIDTH +: IN_WIDTH] = link.in_data;

      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;

      if (out_valid_q && link.out_ready) begin
         out_valid_d = 1'b0;
      end

      if (complete) begin
         out_data_d  = merged;
         out_count_d = cnt_q + CNT_W'(1);
         out_valid_d = 1'b1;
         acc_d       = '0;
         cnt_d       = '0;
      end else if (accept) begin
         acc_d       = merged;
         cnt_d       = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_count_q <= '0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
      end
   end

   assign link.in_ready  = in_ready;
   assign link.out_valid = out_valid_q;
   assign link.out_data  = out_data_q;
   assign link.out_count = out_count_q;
endmodule

// File: tb/tb_param_width_deser.sv
// Bench for param_width_deser: directed scenarios plus random traffic, checked every cycle
// against a beat-list model and a word scoreboard.
module tb_param_width_deser;
   localparam int IN_W  = 8;
   localparam int RATIO = 2;
   localparam int OUT_W = IN_W * RATIO;
   localparam int CNT_W = $clog2(RATIO + 1);

   logic clk;
   logic rst;

   param_width_deser_if #(.IN_WIDTH(IN_W), .RATIO(RATIO)) link ();

   param_width_deser #(.IN_WIDTH(IN_W), .RATIO(RATIO)) dut (
      .clk  (clk),
      .rst  (rst),
      .link (link)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      else passed++;
   endtask

   task automatic fail_now(input string name);
      total++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Model: beats of the word in progress, the presented output word, and words owed downstream.
   logic [IN_W-1:0]        part_q[$];
   logic [CNT_W+OUT_W-1:0] exp_q[$];
   logic                   m_ov;
   logic [OUT_W-1:0]       m_data;
   logic [CNT_W-1:0]       m_cnt;
   logic                   m_acc;
   logic                   started = 1'b0;

   always begin
      logic             rdy;
      logic             done;
      logic [OUT_W-1:0] w;
      logic [CNT_W+OUT_W-1:0] e;
      @(posedge clk);
      m_acc = 1'b0;
      if (rst) begin
         part_q.delete();
         exp_q.delete();
         m_ov    = 1'b0;
         m_data  = '0;
         m_cnt   = '0;
         started = 1'b1;
      end else if (started) begin
         if (link.out_valid && link.out_ready) begin
            if (exp_q.size() == 0) fail_now("word_unexpected");
            else begin
               e = exp_q.pop_front();
               check("word", {link.out_count, link.out_data}, e);
            end
         end
         rdy  = !m_ov || link.out_ready;
         done = 1'b0;
         if (link.in_valid && rdy) begin
            m_acc = 1'b1;
            part_q.push_back(link.in_data);
            if (link.in_last || part_q.size() == RATIO) begin
               w = '0;
               for (int k = 0; k < part_q.size(); k++) w[k*IN_W +: IN_W] = part_q[k];
               m_data = w;
               m_cnt  = CNT_W'(part_q.size());
               m_ov   = 1'b1;
               exp_q.push_back({m_cnt, m_data});
               part_q.delete();
               done = 1'b1;
            end
         end
         if (!done && m_ov && link.out_ready) m_ov = 1'b0;
      end
      #1;
      if (started) begin
         check("in_ready", link.in_ready, !m_ov || link.out_ready);
         check("out_valid", link.out_valid, m_ov);
         check("out_data", link.out_data, m_data);
         check("out_count", link.out_count, m_cnt);
      end
   end

   // Presents one beat from the next falling edge and holds it until the model sees it taken.
   task automatic send_beat(input logic [IN_W-1:0] d, input logic last, output int cycles);
      logic got;
      got    = 1'b0;
      cycles = 0;
      @(negedge clk);
      link.in_valid = 1'b1;
      link.in_data  = d;
      link.in_last  = last;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #2;
         cycles++;
         if (m_acc) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) fail_now("beat_timeout");
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      link.in_valid = 1'b0;
      link.in_last  = 1'b0;
      repeat (n - 1) @(negedge clk);
   endtask

   initial begin
      int cyc;
      rst            = 1'b1;
      link.in_valid  = 1'b1;
      link.in_data   = 8'hFF;
      link.in_last   = 1'b0;
      link.out_ready = 1'b1;

      // Reset with in_valid high
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst           = 1'b0;
      link.in_valid = 1'b0;
      @(posedge clk);
      #2;
      check("rst_out_valid", link.out_valid, 1'b0);
      check("rst_out_data", link.out_data, 16'h0000);
      check("rst_out_count", link.out_count, 2'd0);
      check("rst_in_ready", link.in_ready, 1'b1);

      // Plain pack
      send_beat(8'hA1, 1'b0, cyc);
      send_beat(8'hB2, 1'b0, cyc);
      check("pack_valid", link.out_valid, 1'b1);
      check("pack_data", link.out_data, 16'hB2A1);
      check("pack_count", link.out_count, 2'd2);
      idle(2);

      // Early flush, then the next beat restarts at slot 0
      send_beat(8'h5C, 1'b1, cyc);
      check("flush_data", link.out_data, 16'h005C);
      check("flush_count", link.out_count, 2'd1);
      send_beat(8'h11, 1'b0, cyc);
      send_beat(8'h22, 1'b0, cyc);
      check("after_flush_data", link.out_data, 16'h2211);
      idle(2);

      // Backpressure with a beat waiting
      @(negedge clk);
      link.out_ready = 1'b0;
      send_beat(8'hA1, 1'b0, cyc);
      send_beat(8'hB2, 1'b0, cyc);
      @(negedge clk);
      link.in_data = 8'h33;
      link.in_last = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #2;
         check("stall_in_ready", link.in_ready, 1'b0);
         check("stall_valid", link.out_valid, 1'b1);
         check("stall_data", link.out_data, 16'hB2A1);
      end
      @(negedge clk);
      link.out_ready = 1'b1;
      @(posedge clk);
      #2;
      check("release_accept", m_acc, 1'b1);
      check("release_valid", link.out_valid, 1'b0);
      check("release_in_ready", link.in_ready, 1'b1);
      send_beat(8'h44, 1'b0, cyc);
      check("release_word", link.out_data, 16'h4433);
      idle(2);

      // Back-to-back streaming: every beat must go in on its first cycle
      for (int i = 0; i < 8; i++) begin
         send_beat(IN_W'(i), 1'b0, cyc);
         check("stream_no_bubble", cyc, 1);
      end
      check("stream_last_word", link.out_data, 16'h0706);
      idle(2);

      // Reset discards a half-built word
      send_beat(8'h77, 1'b0, cyc);
      idle(1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      send_beat(8'h01, 1'b0, cyc);
      send_beat(8'h02, 1'b0, cyc);
      check("mid_rst_data", link.out_data, 16'h0201);
      check("mid_rst_count", link.out_count, 2'd2);
      idle(2);

      // Random traffic and backpressure
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         link.in_valid  = ($urandom_range(0, 1) == 1);
         link.in_data   = IN_W'($urandom_range(0, 255));
         link.in_last   = ($urandom_range(0, 3) == 0);
         link.out_ready = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      link.in_valid  = 1'b0;
      link.in_last   = 1'b0;
      link.out_ready = 1'b1;
      repeat (4) @(negedge clk);
      check("drain_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
